sdram_pattern_tester: RTL and testbench

//  Self-checking SDRAM exerciser. Writes a deterministic pattern over NUM_WORDS consecutive

---
 rtl/sdram_test_pkg.sv | 26 ++
 rtl/button_edge.sv | 32 +++
 rtl/sdram_pattern_tester.sv | 224 ++++++++++++++++++++++
 tb/tb_sdram_pattern_tester.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_test_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_test_pkg
//  Description : Shared definitions for the SDRAM pattern tester: FSM state
//                encodings and the test-pattern generator function.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_test_pkg;

    localparam logic [2:0] S_WRITE  = 3'd0;
    localparam logic [2:0] S_WWAIT  = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_RWAIT  = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    // Pattern word for a given absolute address. Callers truncate the result
    // to their data width. Odd passes invert every bit so each cell sees both
    // polarities across consecutive passes.
    function automatic logic [63:0] pat(input logic [63:0] addr,
                                        input logic [63:0] seed,
                                        input logic        inv);
        return addr ^ seed ^ {64{inv}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_edge.sv
`default_nettype none
// ============================================================================
//  Module      : button_edge
//  Description : Three-flop synchroniser for an asynchronous active-high
//                pushbutton, producing a single-cycle pulse per press.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_button      - raw asynchronous button input
//                o_rise        - one-cycle pulse on a synchronised rising edge
//  Revision    : 1.0 - initial release
// ============================================================================
module button_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_button,
    output logic o_rise
);

    logic [2:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], i_button};
        end
    end

    // r_sync[0] may be metastable; only the settled stages form the edge.
    assign o_rise = (r_sync[2:1] == 2'b01);

endmodule
`default_nettype wire

// File: rtl/sdram_pattern_tester.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_pattern_tester
//  Description : Self-checking SDRAM exerciser. Writes a pattern over
//                NUM_WORDS addresses, reads it back, counts mismatches and
//                timeouts, then pages the result onto the LEDs, one page per
//                button press. The last page press starts the next pass.
//  Ports       : clk, rst, button           - board side
//                address, req_write, req_read, data_in,
//                data_out, data_valid, write_complete - controller port
//                led, done, pass_ok, err_count       - results
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_pattern_tester
    import sdram_test_pkg::*;
#(
    parameter int                ADDR_W     = 24,
    parameter int                DATA_W     = 32,
    parameter int                LED_W      = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = 24'd32,
    parameter int                NUM_WORDS  = 256,
    parameter logic [31:0]       SEED       = 32'h12345678,
    parameter int                TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button,
    output logic [ADDR_W-1:0] address,
    output logic              req_write,
    output logic              req_read,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    input  logic              data_valid,
    input  logic              write_complete,
    output logic [LED_W-1:0]  led,
    output logic              done,
    output logic              pass_ok,
    output logic [15:0]       err_count
);

    localparam int              c_NPAGE    = DATA_W / LED_W + 1;
    localparam int              c_PAGE_W   = $clog2(c_NPAGE);
    localparam int              c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NUM_WORDS - 1);

    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_idx;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [15:0]         r_pass_n;
    logic [c_PAGE_W-1:0] r_page;
    logic [DATA_W-1:0]   r_first_bad;
    logic                r_have_bad;
    logic [15:0]         r_err;
    logic                r_pass_ok;
    logic                r_done;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data_in;
    logic                r_req_w;
    logic                r_req_r;
    logic [LED_W-1:0]    r_led;

    logic                w_rise;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_pat;
    logic                w_tmo;
    logic                w_last;
    logic [15:0]         w_err_inc;
    logic                w_wr_go;
    logic                w_wr_bad;
    logic                w_rd_go;
    logic                w_rd_bad;
    logic                w_mismatch;
    logic [63:0]         w_pn_ext;
    logic [c_PAGE_W-1:0] w_sel;
    logic [DATA_W-1:0]   w_fb_shift;
    logic [LED_W-1:0]    w_page0;
    logic [LED_W-1:0]    w_led_view;
    logic                w_unused;

    button_edge u_button_edge (
        .clk      (clk),
        .rst      (rst),
        .i_button (button),
        .o_rise   (w_rise)
    );

    assign w_addr     = START_ADDR + r_idx;
    assign w_pat      = DATA_W'(pat(64'(w_addr), 64'(SEED), r_pass_n[0]));
    // The counter is compared before it increments, so a response that lands
    // on the cycle the count reaches TIMEOUT is still accepted.
    assign w_tmo      = (r_cnt == c_CNT_W'(TIMEOUT));
    assign w_last     = (r_idx == c_LAST_IDX);
    assign w_err_inc  = (r_err == 16'hFFFF) ? r_err : r_err + 16'd1;
    assign w_mismatch = (data_out != w_pat);

    assign w_wr_go    = write_complete || w_tmo;
    assign w_wr_bad   = !write_complete && w_tmo;
    assign w_rd_go    = data_valid || w_tmo;
    assign w_rd_bad   = data_valid ? w_mismatch : w_tmo;

    // Display pages: 0 is the status page, 1.. are first_bad slices LSB-first.
    assign w_pn_ext   = 64'(r_pass_n);
    assign w_sel      = r_page - c_PAGE_W'(1);
    assign w_fb_shift = r_first_bad >> (LED_W * w_sel);

    generate
        if (LED_W >= 16) begin : g_led_wide
            assign w_page0 = {r_pass_ok, w_pn_ext[LED_W-10:0], r_err[7:0]};
        end else begin : g_led_narrow
            assign w_page0 = {r_pass_ok, w_pn_ext[LED_W-2:0]};
        end
    endgenerate

    assign w_led_view = (r_page == '0) ? w_page0
                      : (r_have_bad ? w_fb_shift[LED_W-1:0] : '0);

    // Upper pass-counter and shifted first_bad bits are intentionally not shown.
    assign w_unused   = ^{w_pn_ext, w_fb_shift};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_WRITE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_pass_n    <= '0;
            r_page      <= '0;
            r_first_bad <= '0;
            r_have_bad  <= 1'b0;
            r_err       <= '0;
            r_pass_ok   <= 1'b0;
            r_done      <= 1'b0;
            r_addr      <= '0;
            r_data_in   <= '0;
            r_req_w     <= 1'b0;
            r_req_r     <= 1'b0;
            r_led       <= '0;
        end else begin
            r_req_w <= 1'b0;
            r_req_r <= 1'b0;
            case (r_state)
                S_WRITE: begin
                    r_addr    <= w_addr;
                    r_data_in <= w_pat;
                    r_req_w   <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= S_WWAIT;
                end
                S_WWAIT: begin
                    if (w_wr_go) begin
                        if (w_wr_bad) begin
                            r_err <= w_err_inc;
                        end
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= S_READ;
                        end else begin
                            r_idx   <= r_idx + ADDR_W'(1);
                            r_state <= S_WRITE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_READ: begin
                    r_addr  <= w_addr;
                    r_req_r <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_RWAIT;
                end
                S_RWAIT: begin
                    if (w_rd_go) begin
                        if (w_rd_bad) begin
                            r_err <= w_err_inc;
                        end
                        if (data_valid && w_mismatch && !r_have_bad) begin
                            r_first_bad <= data_out;
                            r_have_bad  <= 1'b1;
                        end
                        if (w_last) begin
                            r_done    <= 1'b1;
                            r_pass_ok <= (r_err == 16'd0) && !w_rd_bad;
                            r_state   <= S_REPORT;
                        end else begin
                            r_idx   <= r_idx + ADDR_W'(1);
                            r_state <= S_READ;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_REPORT: begin
                    r_led <= w_led_view;
                    if (w_rise) begin
                        if (r_page == c_PAGE_W'(c_NPAGE - 1)) begin
                            r_page     <= '0;
                            r_pass_n   <= r_pass_n + 16'd1;
                            r_err      <= '0;
                            r_have_bad <= 1'b0;
                            r_done     <= 1'b0;
                            r_idx      <= '0;
                            r_state    <= S_WRITE;
                        end else begin
                            r_page <= r_page + c_PAGE_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_WRITE;
                end
            endcase
        end
    end

    assign address   = r_addr;
    assign data_in   = r_data_in;
    assign req_write = r_req_w;
    assign req_read  = r_req_r;
    assign led       = r_led;
    assign done      = r_done;
    assign pass_ok   = r_pass_ok;
    assign err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sdram_pattern_tester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_pattern_tester
//  Description : Bench for sdram_pattern_tester with a behavioural SDRAM
//                model (fixed latency, read corruption, dropped write) and a
//                queue-based scoreboard for requests and pass reports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_pattern_tester;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        button = 1'b0;
    logic [23:0] address;
    logic        req_write;
    logic        req_read;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_valid;
    logic        write_complete;
    logic [7:0]  led;
    logic        done;
    logic        pass_ok;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    sdram_pattern_tester #(.NUM_WORDS(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .button         (button),
        .address        (address),
        .req_write      (req_write),
        .req_read       (req_read),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .write_complete (write_complete),
        .led            (led),
        .done           (done),
        .pass_ok        (pass_ok),
        .err_count      (err_count)
    );

    int n_tot = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_tot++;
        n_bad++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Hand-computed pattern words for addresses 32..35:
    // even pass = (0x20+i) ^ 0x12345678, odd pass = bitwise inverse.
    logic [31:0] PAT_EVEN [4] = '{32'h12345658, 32'h12345659, 32'h1234565A, 32'h1234565B};
    logic [31:0] PAT_ODD  [4] = '{32'hEDCBA9A7, 32'hEDCBA9A6, 32'hEDCBA9A5, 32'hEDCBA9A4};

    typedef struct { logic [23:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic [15:0] err; logic ok; logic [7:0] led; } rep_t;

    wr_t         exp_wr [$];
    logic [23:0] exp_rd [$];
    rep_t        exp_rep[$];
    int          wr_times[$];

    task automatic push_pass(input bit odd, input int nreads);
        for (int i = 0; i < 4; i++) begin
            wr_t e;
            e.a = 24'(32 + i);
            e.d = odd ? PAT_ODD[i] : PAT_EVEN[i];
            exp_wr.push_back(e);
        end
        for (int i = 0; i < nreads; i++) exp_rd.push_back(24'(32 + i));
    endtask

    task automatic push_rep(input logic [15:0] err, input logic ok, input logic [7:0] l);
        rep_t r;
        r.err = err;
        r.ok  = ok;
        r.led = l;
        exp_rep.push_back(r);
    endtask

    // ---------------- SDRAM model ----------------
    logic [31:0] mem [64];
    bit          busy = 0;
    int          lat_left = 0;
    bit          p_wr = 0;
    logic [23:0] p_addr = '0;
    logic [31:0] p_data = '0;
    bit          corrupt_en = 0;
    logic [23:0] drop_addr = '0;
    int          drop_token = 0;
    int          drop_used = 0;
    int          stray_token = 0;
    int          stray_used = 0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        write_complete = 1'b0;
        data_valid     = 1'b0;
        data_out       = '0;
        forever begin
            @(posedge clk);
            #1;
            write_complete = 1'b0;
            data_valid     = 1'b0;
            if (rst) begin
                busy = 0;
            end else begin
                if (busy) begin
                    lat_left--;
                    if (lat_left == 0) begin
                        busy = 0;
                        if (p_wr) begin
                            mem[p_addr[5:0]] = p_data;
                            write_complete   = 1'b1;
                        end else begin
                            data_out   = (corrupt_en && p_addr == 24'd34) ? 32'hDEADBEEF
                                                                          : mem[p_addr[5:0]];
                            data_valid = 1'b1;
                        end
                    end
                end
                if (stray_used != stray_token) begin
                    stray_used = stray_token;
                    data_out   = 32'h0BAD0BAD;
                    data_valid = 1'b1;
                end
                if (req_write || req_read) begin
                    chk("no_overlapping_request", 64'(busy), 64'd0);
                    if (req_write && drop_used != drop_token && address == drop_addr) begin
                        drop_used = drop_token;
                    end else begin
                        busy     = 1;
                        lat_left = LAT;
                        p_wr     = req_write;
                        p_addr   = address;
                        p_data   = data_in;
                    end
                end
            end
        end
    end

    // ---------------- Monitor / scoreboard ----------------
    logic pw = 1'b0;
    logic pr = 1'b0;
    logic pd = 1'b0;
    wr_t  m_w;
    rep_t m_r;

    initial begin
        forever begin
            @(negedge clk);
            if (req_write) begin
                chk("req_write_one_cycle", 64'(pw), 64'd0);
                wr_times.push_back(cyc);
                if (exp_wr.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    m_w = exp_wr.pop_front();
                    chk("write_addr", 64'(address), 64'(m_w.a));
                    chk("write_data", 64'(data_in), 64'(m_w.d));
                end
            end
            if (req_read) begin
                chk("req_read_one_cycle", 64'(pr), 64'd0);
                if (exp_rd.size() == 0) begin
                    fail("unexpected_read");
                end else begin
                    chk("read_addr", 64'(address), 64'(exp_rd.pop_front()));
                end
            end
            if (done && !pd) begin
                pd = 1'b1;
                if (exp_rep.size() == 0) begin
                    fail("unexpected_report");
                end else begin
                    m_r = exp_rep.pop_front();
                    chk("report_err_count", 64'(err_count), 64'(m_r.err));
                    chk("report_pass_ok", 64'(pass_ok), 64'(m_r.ok));
                    repeat (2) @(negedge clk);
                    chk("report_led_page0", 64'(led), 64'(m_r.led));
                end
            end
            pw = req_write;
            pr = req_read;
            pd = done;
        end
    end

    // ---------------- Stimulus ----------------
    task automatic chk_zero(input string tag);
        chk({tag, "_address"}, 64'(address), 64'd0);
        chk({tag, "_data_in"}, 64'(data_in), 64'd0);
        chk({tag, "_led"}, 64'(led), 64'd0);
        chk({tag, "_req_write"}, 64'(req_write), 64'd0);
        chk({tag, "_req_read"}, 64'(req_read), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_pass_ok"}, 64'(pass_ok), 64'd0);
        chk({tag, "_err_count"}, 64'(err_count), 64'd0);
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (!done && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (!done) fail("wait_done_timeout");
        repeat (4) @(negedge clk);
    endtask

    task automatic press(input int hold);
        button = 1'b1;
        repeat (hold) @(negedge clk);
        button = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int k;
        logic [7:0] pages_b [4];
        logic [7:0] pages_c [4];
        pages_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        pages_c = '{8'hA6, 8'hA9, 8'hCB, 8'hED};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");

        // Pass 0: clean.
        push_pass(0, 4);
        push_rep(16'd0, 1'b1, 8'h80);
        rst = 1'b0;
        wait_done(300);
        press(20);  // long hold must still be a single page step
        chk("p0_page1_led", 64'(led), 64'd0);
        chk("p0_done_held", 64'(done), 64'd1);
        for (int i = 2; i <= 4; i++) begin
            press(1);
            chk("p0_page_led", 64'(led), 64'd0);
            chk("p0_done_held", 64'(done), 64'd1);
        end

        // Pass 1: inverted data, address 34 read back corrupted.
        corrupt_en = 1;
        push_pass(1, 4);
        push_rep(16'd1, 1'b0, 8'h01);
        press(1);
        chk("wrap_clears_done", 64'(done), 64'd0);
        wait_done(300);
        for (int i = 0; i < 4; i++) begin
            press(1);
            chk("p1_first_bad_page", 64'(led), 64'(pages_b[i]));
        end
        corrupt_en = 0;

        // Pass 2: second write never acknowledged -> one timeout, and the
        // stale cell at 33 (pass-1 data) reads back as a mismatch.
        drop_addr = 24'd33;
        drop_token++;
        push_pass(0, 4);
        push_rep(16'd2, 1'b0, 8'h02);
        wr_times.delete();
        press(1);
        wait_done(3000);
        if (wr_times.size() >= 3) chk("timeout_gap_cycles", 64'(wr_times[2] - wr_times[1]), 64'd1025);
        else fail("timeout_gap_cycles");
        for (int i = 0; i < 4; i++) begin
            press(1);
            chk("p2_first_bad_page", 64'(led), 64'(pages_c[i]));
        end

        // Pass 3: reset while waiting on the first read, then a stray pulse.
        push_pass(1, 1);
        press(1);
        k = 0;
        while (!req_read && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (!req_read) fail("wait_first_read");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("mid_reset");
        push_pass(0, 4);
        push_rep(16'd0, 1'b1, 8'h80);
        rst = 1'b0;
        @(negedge clk);
        stray_token++;
        wait_done(300);

        chk("write_queue_drained", 64'(exp_wr.size()), 64'd0);
        chk("read_queue_drained", 64'(exp_rd.size()), 64'd0);
        chk("report_queue_drained", 64'(exp_rep.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
